// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the up/down counter family.
// Direction encodings and the clamped parallel-load computation.
package cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Saturate a load value to modulus-1; modulus is 33 bits so 2**32 fits.
    function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                               input logic [32:0] modulus);
        logic [32:0] lim;
        lim = modulus - 33'd1;
        return ({1'b0, value} > lim) ? lim[31:0] : value;
    endfunction

endpackage

// File: rtl/updown_count_mod_if.sv
// Control/status bundle for one updown_count_mod stage.
// The master drives load/enable/direction and observes count, Tc and Wrap.
interface updown_count_mod_if #(parameter int N = 4);

    logic         L;
    logic         E;
    logic         Up;
    logic [N-1:0] R;
    logic [N-1:0] Q;
    logic         Tc;
    logic         Wrap;

    modport master (output L, E, Up, R, input Q, Tc, Wrap);
    modport slave  (input L, E, Up, R, output Q, Tc, Wrap);

endinterface

// File: rtl/cnt_term_detect.sv
// Combinational terminal-value detection for the counter stage.
// Tc is only raised when the coming edge will actually count past the limit.
module cnt_term_detect
    import cnt_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] max_val,
    input  logic         up,
    input  logic         e,
    input  logic         l,
    output logic         at_max,
    output logic         at_min,
    output logic         tc
);

    assign at_max = (q == max_val);
    assign at_min = (q == '0);
    assign tc     = e & ~l & ((up == DIR_UP) ? at_max : at_min);

endmodule

// File: rtl/updown_count_mod.sv
// N-bit up/down modulo counter with clamped load, Tc and registered Wrap pulse.
// Define UPDOWN_SAT_EN to saturate at the limits instead of wrapping.
module updown_count_mod
    import cnt_pkg::*;
#(
    parameter int     N       = 4,
    parameter longint MODULUS = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    updown_count_mod_if.slave  bus
);

    localparam logic [32:0]  MOD_W = 33'(MODULUS);
    localparam logic [N-1:0] MAX_Q = N'(MODULUS - 1);

    logic [N-1:0] q_q, q_d;
    logic         wrap_q, wrap_d;
    logic         at_max, at_min, tc;
    logic         over;
    logic [31:0]  load_val;

    cnt_term_detect #(.N(N)) u_term (
        .q       (q_q),
        .max_val (MAX_Q),
        .up      (bus.Up),
        .e       (bus.E),
        .l       (bus.L),
        .at_max  (at_max),
        .at_min  (at_min),
        .tc      (tc)
    );

    // A corrupted Q above the limit is steered back into range.
    assign over     = (q_q > MAX_Q);
    assign load_val = clamp_load(32'(bus.R), MOD_W);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (bus.L) begin
            q_d = load_val[N-1:0];
        end else if (bus.E) begin
            if (bus.Up == DIR_UP) begin
                if (at_max || over) begin
`ifdef UPDOWN_SAT_EN
                    q_d    = MAX_Q;
`else
                    q_d    = '0;
                    wrap_d = 1'b1;
`endif
                end else begin
                    q_d = q_q + N'(1);
                end
            end else begin
                if (at_min) begin
`ifdef UPDOWN_SAT_EN
                    q_d    = '0;
`else
                    q_d    = MAX_Q;
                    wrap_d = 1'b1;
`endif
                end else if (over) begin
                    q_d = MAX_Q;
                end else begin
                    q_d = q_q - N'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.Tc   = tc;
    assign bus.Wrap = wrap_q;

endmodule

// File: tb/tb_updown_count_mod.sv
// Randomized + directed bench for updown_count_mod (N=4, MODULUS=10),
// including a two-stage cascade; honours UPDOWN_SAT_EN in the reference model.
module tb_updown_count_mod;

    localparam int MOD = 10;
`ifdef UPDOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic cas_en = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int mq = 0;
    bit mw = 1'b0;

    always #5 Clock = ~Clock;

    updown_count_mod_if #(.N(4)) dif ();
    updown_count_mod_if #(.N(4)) c0_if ();
    updown_count_mod_if #(.N(4)) c1_if ();

    updown_count_mod #(.N(4), .MODULUS(MOD)) u_dut (.Clock(Clock), .Reset(Reset), .bus(dif));
    updown_count_mod #(.N(4), .MODULUS(MOD)) u_c0  (.Clock(Clock), .Reset(Reset), .bus(c0_if));
    updown_count_mod #(.N(4), .MODULUS(MOD)) u_c1  (.Clock(Clock), .Reset(Reset), .bus(c1_if));

    assign c0_if.E = cas_en;
    assign c1_if.E = c0_if.Tc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the range 0..MOD-1.
    function automatic void mdl(input int q, input bit l, input bit e, input bit up,
                                input int r, output int nq, output bit w);
        w  = 1'b0;
        nq = q;
        if (l)            nq = (r > MOD - 1) ? MOD - 1 : r;
        else if (e && up) begin
            if (q == MOD - 1) begin nq = SAT ? q : 0;       w = !SAT; end
            else              nq = q + 1;
        end else if (e) begin
            if (q == 0)       begin nq = SAT ? 0 : MOD - 1; w = !SAT; end
            else              nq = q - 1;
        end
    endfunction

    function automatic bit mdl_tc(input int q, input bit l, input bit e, input bit up);
        return e && !l && (up ? (q == MOD - 1) : (q == 0));
    endfunction

    task automatic step(input bit l, input bit e, input bit up, input int r);
        int nq;
        bit nw;
        @(negedge Clock);
        dif.L = l; dif.E = e; dif.Up = up; dif.R = 4'(r);
        #1 chk("tc", {31'd0, dif.Tc}, {31'd0, mdl_tc(mq, l, e, up)});
        mdl(mq, l, e, up, r, nq, nw);
        @(posedge Clock);
        #1;
        mq = nq;
        mw = nw;
        chk("q", {28'd0, dif.Q}, mq);
        chk("wrap", {31'd0, dif.Wrap}, {31'd0, mw});
    endtask

    // Reset raised between edges must clear outputs before the next edge.
    task automatic async_reset();
        #2 Reset = 1'b1;
        #1;
        chk("rst_q", {28'd0, dif.Q}, 0);
        chk("rst_wrap", {31'd0, dif.Wrap}, 0);
        @(negedge Clock);
        Reset = 1'b0;
        mq = 0;
        mw = 1'b0;
    endtask

    initial begin
        int c0q, c1q, n0, n1;
        bit w0, w1, t0;
        dif.L = 0; dif.E = 0; dif.Up = 1; dif.R = '0;
        c0_if.L = 0; c0_if.Up = 1; c0_if.R = '0;
        c1_if.L = 0; c1_if.Up = 1; c1_if.R = '0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_q", {28'd0, dif.Q}, 0);
        chk("reset_wrap", {31'd0, dif.Wrap}, 0);
        @(negedge Clock);
        Reset = 1'b0;

        // count 1..9 then wrap, then abort with a mid-cycle reset
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
        async_reset();

        // down wrap from a loaded zero
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        // load priority over enable, with clamp
        step(1, 1, 1, 13);
        chk("clamp", {28'd0, dif.Q}, 9);
        step(1, 0, 1, 5);
        step(0, 0, 1, 0);
        chk("hold", {28'd0, dif.Q}, 5);
        // limits held repeatedly (saturation when enabled, wrap otherwise)
        step(1, 0, 1, 9);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(7) == 0), ($urandom_range(3) != 0),
                 $urandom_range(1), $urandom_range(15));
        step(0, 1, 1, 0);
        async_reset();

        // two-stage cascade: stage-0 Tc enables stage 1
        c0q = 0;
        c1q = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            cas_en = 1'b1;
            #1;
            t0 = mdl_tc(c0q, 0, 1, 1);
            chk("cas_tc0", {31'd0, c0_if.Tc}, {31'd0, t0});
            mdl(c0q, 0, 1, 1, 0, n0, w0);
            mdl(c1q, 0, t0, 1, 0, n1, w1);
            @(posedge Clock);
            #1;
            c0q = n0;
            c1q = n1;
            chk("cas_q0", {28'd0, c0_if.Q}, c0q);
            chk("cas_q1", {28'd0, c1_if.Q}, c1q);
            chk("cas_w0", {31'd0, c0_if.Wrap}, {31'd0, w0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
